// File: rtl/jtframe_sdram_mux.sv
// SDRAM bank-0 arbiter: game master has priority, NAUX aux masters served round-robin.
// Define JTFRAME_SDRAM_MUX_FAIR_EN to compile in the aux starvation limiter (MAXWAIT).
module jtframe_sdram_mux #(
   parameter int AW      = 22,
   parameter int NAUX    = 2,
   parameter int MAXWAIT = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [AW-1:0]        game_addr,
   input  logic                 game_rd,
   input  logic                 game_wr,
   input  logic [15:0]          game_din,
   input  logic [1:0]           game_din_m,
   output logic                 game_ack,
   output logic                 game_dst,
   output logic                 game_rdy,
   input  logic [NAUX*AW-1:0]   aux_addr,
   input  logic [NAUX*16-1:0]   aux_din,
   input  logic [NAUX*2-1:0]    aux_din_m,
   input  logic [NAUX-1:0]      aux_rd,
   input  logic [NAUX-1:0]      aux_wr,
   output logic [NAUX-1:0]      aux_busy,
   output logic [NAUX*16-1:0]   aux_dout,
   output logic [AW-1:0]        ba0_addr,
   output logic                 ba0_rd,
   output logic                 ba0_wr,
   output logic [15:0]          ba0_din,
   output logic [1:0]           ba0_din_m,
   input  logic                 ba0_ack,
   input  logic                 ba0_dst,
   input  logic                 ba0_rdy,
   input  logic [15:0]          data_read
);

   localparam int OW = (NAUX > 1) ? $clog2(NAUX) : 1;

   typedef enum logic [1:0] {IDLE, GAME, AUX} state_t;

   state_t          state_reg, state_next;
   logic [OW-1:0]   owner_reg, last_reg, sel;
   logic [NAUX-1:0] pend_reg, kind_reg, busy_reg;
   logic            any_pend, forced, grant_game, grant_aux;
   int              idx;

   assign any_pend = |pend_reg;
   assign aux_busy = busy_reg;

   // Round-robin pick: first pending master after the last one served
   always_comb begin
      sel = last_reg;
      idx = 0;
      for (int k = NAUX; k >= 1; k--) begin
         idx = (int'(last_reg) + k) % NAUX;
         if (pend_reg[idx]) sel = OW'(idx);
      end
   end

`ifdef JTFRAME_SDRAM_MUX_FAIR_EN
   logic [3:0] wait_reg;

   assign forced = (wait_reg == 4'(MAXWAIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_reg <= 4'd0;
      end else if (grant_aux) begin
         wait_reg <= 4'd0;
      end else if (grant_game) begin
         wait_reg <= any_pend ? wait_reg + 4'd1 : 4'd0;
      end
   end
`else
   assign forced = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      grant_game = 1'b0;
      grant_aux  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (forced && any_pend) begin
               grant_aux = 1'b1;
            end else if (game_rd || game_wr) begin
               grant_game = 1'b1;
            end else if (any_pend) begin
               grant_aux = 1'b1;
            end
            if (grant_aux)  state_next = AUX;
            if (grant_game) state_next = GAME;
         end
         GAME, AUX: if (ba0_rdy) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         owner_reg <= '0;
         last_reg  <= OW'(NAUX-1);
      end else begin
         state_reg <= state_next;
         if (grant_aux) begin
            owner_reg <= sel;
            last_reg  <= sel;
         end
      end
   end

   // Bank-side mux; the address/data path is forced low while in reset
   always_comb begin
      ba0_addr   = game_addr;
      ba0_din    = game_din;
      ba0_din_m  = game_din_m;
      ba0_rd     = 1'b0;
      ba0_wr     = 1'b0;
      game_ack   = 1'b0;
      game_dst   = 1'b0;
      game_rdy   = 1'b0;
      case (state_reg)
         GAME: begin
            ba0_rd   = game_rd;
            ba0_wr   = game_wr;
            game_ack = ba0_ack;
            game_dst = ba0_dst;
            game_rdy = ba0_rdy;
         end
         AUX: begin
            ba0_addr  = aux_addr[int'(owner_reg)*AW +: AW];
            ba0_din   = aux_din[int'(owner_reg)*16 +: 16];
            ba0_din_m = aux_din_m[int'(owner_reg)*2 +: 2];
            ba0_rd    = pend_reg[owner_reg] & ~kind_reg[owner_reg];
            ba0_wr    = pend_reg[owner_reg] &  kind_reg[owner_reg];
         end
         default: ;
      endcase
      if (!rst_n) begin
         ba0_addr  = '0;
         ba0_din   = '0;
         ba0_din_m = '0;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NAUX; gi++) begin : g_aux
         logic        pend_q, kind_q, busy_q, served;
         logic [15:0] dout_q;

         assign served                = (state_reg == AUX) && (owner_reg == OW'(gi));
         assign pend_reg[gi]          = pend_q;
         assign kind_reg[gi]          = kind_q;
         assign busy_reg[gi]          = busy_q;
         assign aux_dout[gi*16 +: 16] = dout_q;

         // A new strobe is accepted only while idle; write wins over read
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pend_q <= 1'b0;
               kind_q <= 1'b0;
               busy_q <= 1'b0;
               dout_q <= 16'd0;
            end else if (!busy_q && (aux_rd[gi] || aux_wr[gi])) begin
               pend_q <= 1'b1;
               kind_q <= aux_wr[gi];
               busy_q <= 1'b1;
            end else if (served) begin
               if (ba0_ack) pend_q <= 1'b0;
               if (ba0_rdy) busy_q <= 1'b0;
               if (ba0_dst) dout_q <= data_read;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_jtframe_sdram_mux.sv
// Scoreboard bench for jtframe_sdram_mux with a small SDRAM bank model.
module tb_jtframe_sdram_mux;
   localparam int AW = 22, NAUX = 2, MAXWAIT = 3;

   logic              clk = 0, rst_n = 0;
   logic [AW-1:0]     game_addr;
   logic              game_rd, game_wr;
   logic [15:0]       game_din;
   logic [1:0]        game_din_m;
   logic              game_ack, game_dst, game_rdy;
   logic [NAUX*AW-1:0] aux_addr;
   logic [NAUX*16-1:0] aux_din;
   logic [NAUX*2-1:0]  aux_din_m;
   logic [NAUX-1:0]    aux_rd, aux_wr, aux_busy;
   logic [NAUX*16-1:0] aux_dout;
   logic [AW-1:0]     ba0_addr;
   logic              ba0_rd, ba0_wr;
   logic [15:0]       ba0_din;
   logic [1:0]        ba0_din_m;
   logic              ba0_ack, ba0_dst, ba0_rdy;
   logic [15:0]       data_read;

   typedef struct packed {
      logic          game;
      logic          wr;
      logic [AW-1:0] addr;
      logic [15:0]   din;
      logic [1:0]    m;
   } exp_t;

   exp_t sbq[$];
   int   total = 0, passed = 0;
   int   m_st = 0;
   logic m_is_wr = 0;
   logic cur_game = 0;
   logic prev_req = 0;

   jtframe_sdram_mux #(.AW(AW), .NAUX(NAUX), .MAXWAIT(MAXWAIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .game_addr(game_addr), .game_rd(game_rd), .game_wr(game_wr),
      .game_din(game_din), .game_din_m(game_din_m),
      .game_ack(game_ack), .game_dst(game_dst), .game_rdy(game_rdy),
      .aux_addr(aux_addr), .aux_din(aux_din), .aux_din_m(aux_din_m),
      .aux_rd(aux_rd), .aux_wr(aux_wr), .aux_busy(aux_busy), .aux_dout(aux_dout),
      .ba0_addr(ba0_addr), .ba0_rd(ba0_rd), .ba0_wr(ba0_wr),
      .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
      .ba0_ack(ba0_ack), .ba0_dst(ba0_dst), .ba0_rdy(ba0_rdy),
      .data_read(data_read)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s got=%h expected=%h", name, got, exp);
   endtask

   function automatic logic [15:0] data_of(input logic [AW-1:0] a);
      return (a == 22'h1234) ? 16'hBEEF : (a[15:0] ^ 16'hA5A5);
   endfunction

   function automatic exp_t mk(input logic g, input logic w, input logic [AW-1:0] a,
                               input logic [15:0] d, input logic [1:0] mm);
      exp_t e;
      e.game = g; e.wr = w; e.addr = a; e.din = d; e.m = mm;
      return e;
   endfunction

   // Bank model: ack one cycle after the request, dst (reads only), then rdy
   initial begin
      ba0_ack = 0; ba0_dst = 0; ba0_rdy = 0; data_read = 0;
      forever begin
         @(posedge clk); #1;
         ba0_ack = 0; ba0_dst = 0; ba0_rdy = 0;
         if (!rst_n) m_st = 0;
         else case (m_st)
            0: if (ba0_rd || ba0_wr) begin
                  m_is_wr = ba0_wr; data_read = data_of(ba0_addr); m_st = 1;
               end
            1: begin ba0_ack = 1; m_st = 2; end
            2: begin ba0_dst = !m_is_wr; m_st = 3; end
            default: begin ba0_rdy = 1; m_st = 0; end
         endcase
      end
   end

   // Monitor: every new bank request is matched against the scoreboard head
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && (ba0_rd || ba0_wr) && !prev_req) begin
            if (sbq.size() == 0) begin
               check("unexpected_grant", {10'd0, ba0_addr}, 32'hFFFFFFFF);
            end else begin
               e = sbq.pop_front();
               cur_game = e.game;
               $display("grant %s wr=%0d addr=%h din=%h m=%b", e.game ? "game" : "aux ",
                        ba0_wr, ba0_addr, ba0_din, ba0_din_m);
               check("grant_wr",   {31'd0, ba0_wr}, {31'd0, e.wr});
               check("grant_rd",   {31'd0, ba0_rd}, {31'd0, ~e.wr});
               check("grant_addr", {10'd0, ba0_addr}, {10'd0, e.addr});
               check("grant_din",  {16'd0, ba0_din}, {16'd0, e.din});
               check("grant_mask", {30'd0, ba0_din_m}, {30'd0, e.m});
            end
         end
         if (rst_n && (ba0_ack || ba0_dst || ba0_rdy)) begin
            if (cur_game)
               check("game_pass", {29'd0, game_ack, game_dst, game_rdy}, {29'd0, ba0_ack, ba0_dst, ba0_rdy});
            else
               check("game_gate", {29'd0, game_ack, game_dst, game_rdy}, 32'd0);
         end
         prev_req = ba0_rd || ba0_wr;
      end
   end

   task automatic set_aux(input int i, input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] mm);
      aux_addr[i*AW +: AW] = a;
      aux_din[i*16 +: 16]  = d;
      aux_din_m[i*2 +: 2]  = mm;
   endtask

   task automatic wait_quiet(input string name);
      logic ok;
      ok = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (aux_busy == 0 && m_st == 0 && !ba0_rd && !ba0_wr && !game_rd && !game_wr) begin
            ok = 1;
            break;
         end
      end
      check(name, {31'd0, ok}, 32'd1);
      @(negedge clk);
   endtask

   // Holds the game request until game_rdy, counting game_dst pulses
   task automatic game_txn(input logic w, input logic [AW-1:0] a, input logic [15:0] d,
                           input logic [1:0] mm, output int dst_cnt);
      logic done;
      done = 0; dst_cnt = 0;
      game_addr = a; game_din = d; game_din_m = mm; game_rd = !w; game_wr = w;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         dst_cnt += int'(game_dst);
         if (game_rdy) begin done = 1; break; end
      end
      game_rd = 0; game_wr = 0;
      check("game_rdy_seen", {31'd0, done}, 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int  dst_cnt, rdy_cnt;
      logic done, stray;
      game_addr = 22'h1234; game_rd = 0; game_wr = 0; game_din = 0; game_din_m = 0;
      aux_addr = 0; aux_din = 0; aux_din_m = 0; aux_rd = 0; aux_wr = 0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_addr", {10'd0, ba0_addr}, 32'd0);
      check("rst_req", {30'd0, ba0_rd, ba0_wr}, 32'd0);
      check("rst_busy", {30'd0, aux_busy}, 32'd0);
      check("rst_dout", aux_dout, 32'd0);
      check("rst_game", {29'd0, game_ack, game_dst, game_rdy}, 32'd0);
      rst_n = 1;
      @(negedge clk);
      check("idle_addr", {10'd0, ba0_addr}, 32'h1234);
      check("idle_req", {30'd0, ba0_rd, ba0_wr}, 32'd0);

      // Game-only read, request visible one cycle after it is raised
      sbq.push_back(mk(1, 0, 22'h1234, 16'h0000, 2'b00));
      game_rd = 1;
      @(negedge clk);
      check("game_lat", {31'd0, ba0_rd}, 32'd1);
      game_txn(0, 22'h1234, 16'h0000, 2'b00, dst_cnt);
      check("game_dst_cnt", dst_cnt, 32'd1);
      check("game_aux_busy", {30'd0, aux_busy}, 32'd0);
      wait_quiet("quiet_game");

      // Aux write on master 1, granted two cycles after the strobe
      set_aux(1, 22'h0100, 16'h55AA, 2'b00);
      sbq.push_back(mk(0, 1, 22'h0100, 16'h55AA, 2'b00));
      aux_wr = 2'b10;
      @(negedge clk);
      aux_wr = 0;
      check("aux_lat_n1", {31'd0, ba0_wr}, 32'd0);
      check("aux_busy_set", {30'd0, aux_busy}, 32'd2);
      @(negedge clk);
      check("aux_lat_n2", {31'd0, ba0_wr}, 32'd1);
      // A strobe in the rdy cycle must be dropped
      done = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         aux_wr = 0;
         if (!aux_busy[1]) begin done = 1; break; end
         if (ba0_rdy) begin aux_wr = 2'b10; set_aux(1, 22'h0777, 16'h7777, 2'b11); end
      end
      aux_wr = 0;
      check("aux_busy_fall", {31'd0, done}, 32'd1);
      wait_quiet("quiet_auxwr");
      check("strobe_at_rdy_dropped", {30'd0, aux_busy}, 32'd0);

      // Round-robin: both aux masters strobe together; last served was 1
      set_aux(0, 22'h0010, 16'h1111, 2'b01);
      set_aux(1, 22'h0020, 16'h2222, 2'b10);
      sbq.push_back(mk(0, 0, 22'h0010, 16'h1111, 2'b01));
      sbq.push_back(mk(0, 0, 22'h0020, 16'h2222, 2'b10));
      aux_rd = 2'b11;
      @(negedge clk);
      aux_rd = 0;
      wait_quiet("quiet_rr");
      check("rr_dout0", {16'd0, aux_dout[15:0]}, 32'hA5B5);
      check("rr_dout1", {16'd0, aux_dout[31:16]}, 32'hA585);
      set_aux(0, 22'h0030, 16'h3333, 2'b00);
      sbq.push_back(mk(0, 1, 22'h0030, 16'h3333, 2'b00));
      aux_wr = 2'b01;
      @(negedge clk);
      aux_wr = 0;
      wait_quiet("quiet_rr2");

      // Game and aux pending together in IDLE: game goes first
      set_aux(1, 22'h0040, 16'h4444, 2'b11);
      sbq.push_back(mk(1, 0, 22'h2000, 16'h0000, 2'b00));
      sbq.push_back(mk(0, 1, 22'h0040, 16'h4444, 2'b11));
      aux_wr = 2'b10;
      @(negedge clk);
      aux_wr = 0;
      game_txn(0, 22'h2000, 16'h0000, 2'b00, dst_cnt);
      wait_quiet("quiet_simul");

      // Continuous game traffic with aux 0 pending
      set_aux(0, 22'h0050, 16'h0000, 2'b00);
      game_addr = 22'h3000; game_din = 0; game_din_m = 0; game_rd = 1;
      sbq.push_back(mk(1, 0, 22'h3000, 16'h0000, 2'b00));
      @(negedge clk);
      aux_rd = 2'b01;
      @(negedge clk);
      aux_rd = 0;
`ifdef JTFRAME_SDRAM_MUX_FAIR_EN
      repeat (3) sbq.push_back(mk(1, 0, 22'h3000, 16'h0000, 2'b00));
      sbq.push_back(mk(0, 0, 22'h0050, 16'h0000, 2'b00));
      sbq.push_back(mk(1, 0, 22'h3000, 16'h0000, 2'b00));
`else
      repeat (4) sbq.push_back(mk(1, 0, 22'h3000, 16'h0000, 2'b00));
      sbq.push_back(mk(0, 0, 22'h0050, 16'h0000, 2'b00));
`endif
      rdy_cnt = 0;
      for (int c = 0; c < 400 && rdy_cnt < 5; c++) begin
         @(negedge clk);
         if (game_rdy) rdy_cnt++;
      end
      game_rd = 0;
      check("starve_game_cnt", rdy_cnt, 32'd5);
`ifdef JTFRAME_SDRAM_MUX_FAIR_EN
      check("fair_aux_served", {31'd0, aux_busy[0]}, 32'd0);
`else
      check("strict_aux_waits", {31'd0, aux_busy[0]}, 32'd1);
`endif
      wait_quiet("quiet_starve");
      check("starve_dout0", {16'd0, aux_dout[15:0]}, 32'hA5F5);
      check("starve_sb_drained", sbq.size(), 32'd0);

      // Reset while aux 0 is reading
      set_aux(0, 22'h0060, 16'h6666, 2'b01);
      sbq.push_back(mk(0, 0, 22'h0060, 16'h6666, 2'b01));
      aux_rd = 2'b01;
      @(negedge clk);
      aux_rd = 0;
      done = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (ba0_rd) begin done = 1; break; end
      end
      check("mid_rd_seen", {31'd0, done}, 32'd1);
      rst_n = 0;
      #1;
      check("mid_rst_req", {30'd0, ba0_rd, ba0_wr}, 32'd0);
      check("mid_rst_addr", {10'd0, ba0_addr}, 32'd0);
      check("mid_rst_din", {14'd0, ba0_din_m, ba0_din}, 32'd0);
      check("mid_rst_busy", {30'd0, aux_busy}, 32'd0);
      check("mid_rst_dout", aux_dout, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      stray = 0;
      repeat (4) begin
         @(negedge clk);
         stray = stray | ba0_rd | ba0_wr;
      end
      check("post_rst_no_grant", {31'd0, stray}, 32'd0);
      check("post_rst_busy", {30'd0, aux_busy}, 32'd0);

      // Normal operation after reset
      sbq.push_back(mk(1, 1, 22'h0ABC, 16'hCAFE, 2'b01));
      game_txn(1, 22'h0ABC, 16'hCAFE, 2'b01, dst_cnt);
      check("game_wr_no_dst", dst_cnt, 32'd0);
      wait_quiet("quiet_final");
      check("sb_empty", sbq.size(), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
